// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic skew feeder: FSM states, default geometry
// and the flush length needed to drain an N x N array.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N     = 4;
    localparam int FLUSH_CYCLES  = 2 * DEFAULT_N - 2;

    // Zero beats needed after the last k-step so the far corner PE sees it.
    function automatic int flush_cycles(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register that advances only when shift is high; one per
// array lane, with depth chosen by the lane index to build the systolic skew.
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else if (shift) begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews A-column and two B-row slices onto the edges of an N x N systolic array,
// flushes zeros after the last k-step and drives the array-wide PE enable.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [N*WIDTH-1:0] left_in,
    input  logic [N*WIDTH-1:0] top1_in,
    input  logic [N*WIDTH-1:0] top2_in,
    output logic [N*WIDTH-1:0] left_out,
    output logic [N*WIDTH-1:0] top1_out,
    output logic [N*WIDTH-1:0] top2_out,
    output logic               pe_enable,
    output logic               busy,
    output logic               done,
    output logic [15:0]        k_count,
    output state_t             fsm_state
);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // upstream must hold the beat stable while in_ready is low.

    localparam int FLUSH_LEN = flush_cycles(N);
    localparam int FCW       = $clog2(FLUSH_LEN + 1);

    state_t         state, state_next;
    logic [FCW-1:0] flush_cnt, flush_cnt_next;
    logic           accept;
    logic           advance;

    assign in_ready  = (state == ST_IDLE) || (state == ST_FEED);
    assign accept    = in_valid && in_ready;
    assign advance   = accept || (state == ST_FLUSH);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            ST_IDLE, ST_FEED: begin
                if (accept) begin
                    if (in_last) begin
                        state_next     = ST_FLUSH;
                        flush_cnt_next = FCW'(FLUSH_LEN);
                    end else begin
                        state_next = ST_FEED;
                    end
                end
            end
            ST_FLUSH: begin
                flush_cnt_next = flush_cnt - FCW'(1);
                if (flush_cnt == FCW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            pe_enable <= 1'b0;
            k_count   <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            // The array consumes whatever the delay lines presented after this edge.
            pe_enable <= advance;
            if (accept) begin
                if (state == ST_IDLE) begin
                    k_count <= 16'd1;
                end else if (k_count != 16'hFFFF) begin
                    k_count <= k_count + 16'd1;
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0] left_d, top1_d, top2_d;

        // Outside an accept the only advances come from FLUSH, which shifts zeros.
        assign left_d = accept ? left_in[i*WIDTH +: WIDTH] : '0;
        assign top1_d = accept ? top1_in[i*WIDTH +: WIDTH] : '0;
        assign top2_d = accept ? top2_in[i*WIDTH +: WIDTH] : '0;

        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_left (
            .clk   (clk),
            .rst   (rst),
            .shift (advance),
            .d     (left_d),
            .q     (left_out[i*WIDTH +: WIDTH])
        );

        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_top1 (
            .clk   (clk),
            .rst   (rst),
            .shift (advance),
            .d     (top1_d),
            .q     (top1_out[i*WIDTH +: WIDTH])
        );

        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_top2 (
            .clk   (clk),
            .rst   (rst),
            .shift (advance),
            .d     (top2_d),
            .q     (top2_out[i*WIDTH +: WIDTH])
        );
    end

endmodule
